// File: rtl/regfile_wb.sv
// regfile_wb: general-purpose register file closing the write-back path; r0 is hardwired to zero.
// Latency: writes commit on the rising clk edge; both read ports are combinational with write-through bypass.
// Backpressure: none, a write can be accepted every cycle. Define REGFILE_FWD_EN to add EX/MEM forwarding.
module regfile_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32   // must equal 2**ADDR_W so every address maps to a real entry
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata
);

  // Architectural state. Entry 0 is never written, so it holds its reset value of zero.
  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write to r0 is dropped here rather than masked at the read side, so storage stays clean.
  logic wr_commit;
  assign wr_commit = we && (waddr != '0);

  // Per-port hit detection for the write-through bypass.
  logic wb_hit1;
  logic wb_hit2;
  assign wb_hit1 = we && (waddr == raddr1);
  assign wb_hit2 = we && (waddr == raddr2);

`ifdef REGFILE_FWD_EN
  // Forwarding hits: EX is the youngest producer, so it is checked ahead of MEM.
  logic ex_hit1;
  logic ex_hit2;
  logic mem_hit1;
  logic mem_hit2;
  assign ex_hit1  = ex_we  && (ex_waddr  == raddr1);
  assign ex_hit2  = ex_we  && (ex_waddr  == raddr2);
  assign mem_hit1 = mem_we && (mem_waddr == raddr1);
  assign mem_hit2 = mem_we && (mem_waddr == raddr2);
`else
  // Without forwarding the hazard unit stalls instead; the EX/MEM inputs are kept on the
  // port list for drop-in compatibility but deliberately go nowhere.
  logic unused_fwd;
  assign unused_fwd = ^{ex_we, ex_waddr, ex_wdata, mem_we, mem_waddr, mem_wdata};
`endif

  // Commit write-back data on the clock edge; reset clears every entry asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: reset, disable and r0 force zero; otherwise youngest producer wins over storage.
  always_comb begin
    rdata1 = '0;
    if (reset && re1 && (raddr1 != '0)) begin
`ifdef REGFILE_FWD_EN
      if (ex_hit1) begin
        rdata1 = ex_wdata;
      end else if (mem_hit1) begin
        rdata1 = mem_wdata;
      end else if (wb_hit1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
`else
      if (wb_hit1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
`endif
    end
  end

  // Read port 2: identical resolution to port 1 so equal addresses always return equal data.
  always_comb begin
    rdata2 = '0;
    if (reset && re2 && (raddr2 != '0)) begin
`ifdef REGFILE_FWD_EN
      if (ex_hit2) begin
        rdata2 = ex_wdata;
      end else if (mem_hit2) begin
        rdata2 = mem_wdata;
      end else if (wb_hit2) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
`else
      if (wb_hit2) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
`endif
    end
  end

endmodule
